// File: rtl/ram_arbiter_if.sv
// Bundle shared by the arbiter: fetch port, data port and the single-port RAM pins.
// slave = arbiter side, master = requesters plus RAM side.
interface ram_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_ack;
  logic        if_valid;
  logic [15:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic        d_valid;
  logic [15:0] d_rdata;

  logic        err;

  logic        ram_read;
  logic        ram_write;
  logic [15:0] ram_address;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_data_out,
    output if_ack, if_valid, if_rdata, d_ack, d_valid, d_rdata, err,
           ram_read, ram_write, ram_address, ram_data_in
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_data_out,
    input  if_ack, if_valid, if_rdata, d_ack, d_valid, d_rdata, err,
           ram_read, ram_write, ram_address, ram_data_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one synchronous-read RAM between the fetch port and the data port,
// serialising requests and trapping out-of-range addresses before the RAM.
//
// state | meaning
// IDLE  | waiting for a request; grants, acks and launches the RAM command
// CMD   | RAM strobe high; writes finish here, reads move on
// RESP  | RAM presenting read data; captured into owner's rdata on exit
module ram_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int MEM_DEPTH  = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  localparam logic        PORT_I  = 1'b0;
  localparam logic        PORT_D  = 1'b1;
  localparam logic [16:0] DEPTH_W = 17'(MEM_DEPTH);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        trap;
  logic        is_write;

  logic        any_req;
  logic        grant_d;
  logic        sel_we;
  logic        oor;
  logic [15:0] sel_addr;

  always_comb begin
    any_req  = bus.if_req || bus.d_req;
    // D wins a tie under fixed priority, or when fetch was granted last
    grant_d  = bus.d_req && (!bus.if_req || FIXED_PRIO || (last_grant == PORT_I));
    sel_addr = grant_d ? bus.d_addr : bus.if_addr;
    sel_we   = grant_d && bus.d_we;
    oor      = {1'b0, sel_addr} >= DEPTH_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      owner           <= PORT_I;
      last_grant      <= PORT_I;
      trap            <= 1'b0;
      is_write        <= 1'b0;
      bus.if_ack      <= 1'b0;
      bus.if_valid    <= 1'b0;
      bus.if_rdata    <= 16'h0000;
      bus.d_ack       <= 1'b0;
      bus.d_valid     <= 1'b0;
      bus.d_rdata     <= 16'h0000;
      bus.err         <= 1'b0;
      bus.ram_read    <= 1'b0;
      bus.ram_write   <= 1'b0;
      bus.ram_address <= 16'h0000;
      bus.ram_data_in <= 16'h0000;
    end else begin
      bus.if_ack      <= 1'b0;
      bus.d_ack       <= 1'b0;
      bus.if_valid    <= 1'b0;
      bus.d_valid     <= 1'b0;
      bus.err         <= 1'b0;
      bus.ram_read    <= 1'b0;
      bus.ram_write   <= 1'b0;
      bus.ram_address <= 16'h0000;
      bus.ram_data_in <= 16'h0000;

      case (state)
        IDLE: begin
          if (any_req) begin
            owner           <= grant_d;
            last_grant      <= grant_d;
            trap            <= oor;
            is_write        <= sel_we;
            bus.d_ack       <= grant_d;
            bus.if_ack      <= !grant_d;
            bus.err         <= oor;
            bus.ram_read    <= !sel_we && !oor;
            bus.ram_write   <= sel_we && !oor;
            bus.ram_address <= {8'h00, sel_addr[7:0]};
            bus.ram_data_in <= (sel_we && !oor) ? bus.d_wdata : 16'h0000;
            state           <= CMD;
          end
        end
        CMD: begin
          state <= is_write ? IDLE : RESP;
        end
        RESP: begin
          if (owner == PORT_D) begin
            bus.d_valid <= 1'b1;
            bus.d_rdata <= trap ? 16'h0000 : bus.ram_data_out;
          end else begin
            bus.if_valid <= 1'b1;
            bus.if_rdata <= trap ? 16'h0000 : bus.ram_data_out;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance (bus0) and a
// fixed-priority instance (bus1), each with its own synchronous-read RAM model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ram_arbiter_if bus0 ();
  ram_arbiter_if bus1 ();

  ram_arbiter #(.FIXED_PRIO(1'b0), .MEM_DEPTH(255)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  ram_arbiter #(.FIXED_PRIO(1'b1), .MEM_DEPTH(255)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [15:0] rd0 = 16'h0000;
  logic [15:0] rd1 = 16'h0000;

  always @(posedge clk) begin
    if (bus0.ram_write) mem0[bus0.ram_address[7:0]] <= bus0.ram_data_in;
    if (bus0.ram_read)  rd0 <= mem0[bus0.ram_address[7:0]];
    if (bus1.ram_write) mem1[bus1.ram_address[7:0]] <= bus1.ram_data_in;
    if (bus1.ram_read)  rd1 <= mem1[bus1.ram_address[7:0]];
  end
  assign bus0.ram_data_out = rd0;
  assign bus1.ram_data_out = rd1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({bus0.if_ack, bus0.if_valid, bus0.d_ack, bus0.d_valid, bus0.err,
         bus0.ram_read, bus0.ram_write, bus0.ram_address, bus0.ram_data_in,
         bus0.if_rdata, bus0.d_rdata} !== 71'h0) begin
      $display("FAIL reset_outputs: some output nonzero during reset (rdata if=%h d=%h addr=%h)",
               bus0.if_rdata, bus0.d_rdata, bus0.ram_address);
      miscompares++;
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'd52;
    tick();
    vectors++;
    if ({bus0.d_ack, bus0.if_ack, bus0.ram_read, bus0.ram_write} !== 4'b1010) begin
      $display("FAIL read_cmd: ack/strobes got %b want 1010", {bus0.d_ack, bus0.if_ack, bus0.ram_read, bus0.ram_write});
      miscompares++;
    end
    vectors++;
    if (bus0.ram_address !== 16'd52) begin
      $display("FAIL read_addr: got %0d want 52", bus0.ram_address);
      miscompares++;
    end
    bus0.d_req = 1'b0;
    tick();
    vectors++;
    if ({bus0.d_valid, bus0.d_ack, bus0.ram_read} !== 3'b000) begin
      $display("FAIL read_resp: valid/ack/read got %b want 000", {bus0.d_valid, bus0.d_ack, bus0.ram_read});
      miscompares++;
    end
    tick();
    vectors++;
    if (bus0.d_valid !== 1'b1 || bus0.d_rdata !== 16'd2) begin
      $display("FAIL read_data: valid=%b rdata=%h want valid=1 rdata=0002", bus0.d_valid, bus0.d_rdata);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus0.d_valid !== 1'b0 || bus0.d_rdata !== 16'd2) begin
      $display("FAIL read_hold: valid=%b rdata=%h want valid=0 rdata=0002", bus0.d_valid, bus0.d_rdata);
      miscompares++;
    end
  endtask

  task automatic test_write_readback();
    bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_addr = 16'd62; bus0.d_wdata = 16'h00AB;
    tick();
    vectors++;
    if ({bus0.d_ack, bus0.ram_write, bus0.ram_read, bus0.err} !== 4'b1100 ||
        bus0.ram_address !== 16'd62 || bus0.ram_data_in !== 16'h00AB) begin
      $display("FAIL write_cmd: ack/wr/rd/err=%b addr=%0d din=%h want 1100 62 00ab",
               {bus0.d_ack, bus0.ram_write, bus0.ram_read, bus0.err}, bus0.ram_address, bus0.ram_data_in);
      miscompares++;
    end
    bus0.d_req = 1'b0; bus0.d_we = 1'b0;
    tick();
    vectors++;
    if (bus0.ram_write !== 1'b0 || bus0.d_valid !== 1'b0 || bus0.ram_data_in !== 16'h0 || mem0[62] !== 16'h00AB) begin
      $display("FAIL write_done: wr=%b valid=%b din=%h mem=%h want 0 0 0000 00ab",
               bus0.ram_write, bus0.d_valid, bus0.ram_data_in, mem0[62]);
      miscompares++;
    end
    bus0.d_req = 1'b1; bus0.d_addr = 16'd62;
    tick();
    vectors++;
    if (bus0.d_ack !== 1'b1 || bus0.ram_read !== 1'b1 || bus0.d_valid !== 1'b0) begin
      $display("FAIL readback_cmd: ack=%b rd=%b valid=%b want 1 1 0", bus0.d_ack, bus0.ram_read, bus0.d_valid);
      miscompares++;
    end
    bus0.d_req = 1'b0;
    repeat (2) tick();
    vectors++;
    if (bus0.d_valid !== 1'b1 || bus0.d_rdata !== 16'h00AB) begin
      $display("FAIL readback_data: valid=%b rdata=%h want 1 00ab", bus0.d_valid, bus0.d_rdata);
      miscompares++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'd10;
    bus0.if_req = 1'b1; bus0.if_addr = 16'd20;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c % 3 == 1) && (((c - 1) / 3) % 2 == 0),
             (c % 3 == 1) && (((c - 1) / 3) % 2 == 1),
             (c % 3 == 0) && (((c - 3) / 3) % 2 == 0),
             (c % 3 == 0) && (((c - 3) / 3) % 2 == 1)};
      vectors++;
      if ({bus0.d_ack, bus0.if_ack, bus0.d_valid, bus0.if_valid} !== exp) begin
        $display("FAIL rr_seq cycle %0d: d_ack,if_ack,d_valid,if_valid got %b want %b",
                 c, {bus0.d_ack, bus0.if_ack, bus0.d_valid, bus0.if_valid}, exp);
        miscompares++;
      end
      if (exp[1]) begin
        vectors++;
        if (bus0.d_rdata !== 16'h1010) begin
          $display("FAIL rr_d_data cycle %0d: got %h want 1010", c, bus0.d_rdata);
          miscompares++;
        end
      end
      if (exp[0]) begin
        vectors++;
        if (bus0.if_rdata !== 16'h2020) begin
          $display("FAIL rr_if_data cycle %0d: got %h want 2020", c, bus0.if_rdata);
          miscompares++;
        end
      end
    end
    bus0.d_req = 1'b0; bus0.if_req = 1'b0;
    tick();
  endtask

  task automatic test_fixed_prio();
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 16'd10;
    bus1.if_req = 1'b1; bus1.if_addr = 16'd20;
    for (int c = 1; c <= 9; c++) begin
      tick();
      vectors++;
      if ({bus1.d_ack, bus1.if_ack} !== ((c % 3 == 1) ? 2'b10 : 2'b00)) begin
        $display("FAIL fp_seq cycle %0d: d_ack,if_ack got %b want %b",
                 c, {bus1.d_ack, bus1.if_ack}, (c % 3 == 1) ? 2'b10 : 2'b00);
        miscompares++;
      end
    end
    bus1.d_req = 1'b0;
    tick();
    vectors++;
    if ({bus1.d_ack, bus1.if_ack} !== 2'b01) begin
      $display("FAIL fp_if_grant: d_ack,if_ack got %b want 01", {bus1.d_ack, bus1.if_ack});
      miscompares++;
    end
    bus1.if_req = 1'b0;
    repeat (2) tick();
    vectors++;
    if (bus1.if_valid !== 1'b1 || bus1.if_rdata !== 16'h2020) begin
      $display("FAIL fp_if_data: valid=%b rdata=%h want 1 2020", bus1.if_valid, bus1.if_rdata);
      miscompares++;
    end
    tick();
  endtask

  task automatic test_out_of_range();
    bus0.if_req = 1'b1; bus0.if_addr = 16'h0100;
    tick();
    vectors++;
    if ({bus0.if_ack, bus0.err, bus0.ram_read, bus0.ram_write} !== 4'b1100) begin
      $display("FAIL oor_fetch_cmd: ack/err/rd/wr got %b want 1100", {bus0.if_ack, bus0.err, bus0.ram_read, bus0.ram_write});
      miscompares++;
    end
    bus0.if_req = 1'b0;
    tick();
    vectors++;
    if ({bus0.ram_read, bus0.if_valid, bus0.err} !== 3'b000) begin
      $display("FAIL oor_fetch_resp: rd/valid/err got %b want 000", {bus0.ram_read, bus0.if_valid, bus0.err});
      miscompares++;
    end
    tick();
    vectors++;
    if (bus0.if_valid !== 1'b1 || bus0.if_rdata !== 16'h0000) begin
      $display("FAIL oor_fetch_data: valid=%b rdata=%h want 1 0000", bus0.if_valid, bus0.if_rdata);
      miscompares++;
    end
    bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_addr = 16'd255; bus0.d_wdata = 16'h5555;
    tick();
    vectors++;
    if ({bus0.d_ack, bus0.err, bus0.ram_write, bus0.ram_read} !== 4'b1100 || bus0.ram_data_in !== 16'h0) begin
      $display("FAIL oor_write_cmd: ack/err/wr/rd=%b din=%h want 1100 0000",
               {bus0.d_ack, bus0.err, bus0.ram_write, bus0.ram_read}, bus0.ram_data_in);
      miscompares++;
    end
    bus0.d_addr = 16'd254;
    tick();
    vectors++;
    if (mem0[255] !== 16'h7777 || bus0.d_valid !== 1'b0) begin
      $display("FAIL oor_write_drop: mem[255]=%h valid=%b want 7777 0", mem0[255], bus0.d_valid);
      miscompares++;
    end
    tick();
    vectors++;
    if ({bus0.d_ack, bus0.err, bus0.ram_write} !== 3'b101 || bus0.ram_address !== 16'd254) begin
      $display("FAIL edge_write_cmd: ack/err/wr=%b addr=%0d want 101 254",
               {bus0.d_ack, bus0.err, bus0.ram_write}, bus0.ram_address);
      miscompares++;
    end
    bus0.d_req = 1'b0; bus0.d_we = 1'b0;
    tick();
    vectors++;
    if (mem0[254] !== 16'h5555) begin
      $display("FAIL edge_write_mem: mem[254]=%h want 5555", mem0[254]);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_read();
    bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 16'd52;
    tick();
    bus0.d_req = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus0.if_ack, bus0.if_valid, bus0.d_ack, bus0.d_valid, bus0.err,
         bus0.ram_read, bus0.ram_write, bus0.ram_address, bus0.ram_data_in,
         bus0.if_rdata, bus0.d_rdata} !== 71'h0) begin
      $display("FAIL reset_async: outputs nonzero after mid-read reset (d_rdata=%h)", bus0.d_rdata);
      miscompares++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if ({bus0.d_valid, bus0.d_ack, bus0.err, bus0.d_rdata} !== 19'h0) begin
      $display("FAIL reset_no_valid: valid/ack/err=%b rdata=%h want 000 0000",
               {bus0.d_valid, bus0.d_ack, bus0.err}, bus0.d_rdata);
      miscompares++;
    end
    bus0.if_req = 1'b1; bus0.if_addr = 16'd0;
    tick();
    vectors++;
    if ({bus0.if_ack, bus0.ram_read} !== 2'b11) begin
      $display("FAIL post_reset_cmd: ack/rd got %b want 11", {bus0.if_ack, bus0.ram_read});
      miscompares++;
    end
    bus0.if_req = 1'b0;
    tick();
    vectors++;
    if (bus0.if_valid !== 1'b0) begin
      $display("FAIL post_reset_early: if_valid=%b want 0", bus0.if_valid);
      miscompares++;
    end
    tick();
    vectors++;
    if (bus0.if_valid !== 1'b1 || bus0.if_rdata !== 16'hC0DE) begin
      $display("FAIL post_reset_data: valid=%b rdata=%h want 1 c0de", bus0.if_valid, bus0.if_rdata);
      miscompares++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    mem0[0]   = 16'hC0DE;
    mem0[52]  = 16'd2;
    mem0[10]  = 16'h1010;
    mem0[20]  = 16'h2020;
    mem0[255] = 16'h7777;
    mem1[10]  = 16'h1010;
    mem1[20]  = 16'h2020;

    bus0.if_req = 1'b0; bus0.if_addr = 16'h0;
    bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_addr = 16'h0; bus0.d_wdata = 16'h0;
    bus1.if_req = 1'b0; bus1.if_addr = 16'h0;
    bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = 16'h0; bus1.d_wdata = 16'h0;

    test_reset();
    test_single_read();
    test_write_readback();
    test_round_robin();
    test_fixed_prio();
    test_out_of_range();
    test_reset_mid_read();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer that shares the processor's single-port, 255-word, synchronous-read RAM between the instruction-fetch path and the data load/store path. It sits between the control unit / datapath and the RAM. It serialises requests, drives the RAM `read`/`write`/`address`/`data_in` pins from registers, and returns each read word to its owner after the RAM's one-cycle read latency. Out-of-range accesses are trapped before reaching the RAM.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin on a tie; 1 means the data port always wins a tie.
- `MEM_DEPTH`, default 255: number of valid words; addresses `>= MEM_DEPTH` are out of range.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `if_req` input 1: fetch request; held high with `if_addr` stable until `if_ack`.
- `if_addr` input 16: fetch address.
- `if_ack` output 1: one-cycle pulse; the request has been accepted.
- `if_valid` output 1: one-cycle pulse; `if_rdata` holds the fetched word.
- `if_rdata` output 16: registered fetch data; holds its value until the next fetch completes.
- `d_req` input 1: data request; `d_we`/`d_addr`/`d_wdata` are held stable until `d_ack`.
- `d_we` input 1: 1 = write, 0 = read.
- `d_addr` input 16: data address.
- `d_wdata` input 16: write data.
- `d_ack` output 1: one-cycle accept pulse.
- `d_valid` output 1: one-cycle pulse on read completion (never pulses for writes).
- `d_rdata` output 16: registered load data; holds its value between loads.
- `err` output 1: one-cycle pulse, coincident with ack, when the accepted access is out of range.
- `ram_read` output 1: RAM read strobe (registered).
- `ram_write` output 1: RAM write strobe (registered).
- `ram_address` output 16: RAM address (registered); bits [15:8] are always 0.
- `ram_data_in` output 16: RAM write data (registered); 0 when not writing.
- `ram_data_out` input 16: RAM read data, valid the cycle after the read strobe is sampled.

## Operation
The FSM has three states: IDLE, CMD, RESP.

- **IDLE**
  - With no request, stay in IDLE.
  - With one or more requests, pick a winner and record its `owner`.
  - At that edge: register the RAM command, pulse the winner's ack, and go to CMD.
- **Arbitration**
  - If only one port requests, it wins.
  - On a tie with `FIXED_PRIO=1`, D wins.
  - On a tie with `FIXED_PRIO=0`, the port not granted last wins. `last_grant` resets to I, so D wins the first tie after reset.
  - `last_grant` updates on every grant, including trapped grants.
- **Range check**
  - An access is out of range when `addr >= MEM_DEPTH`, comparing all 16 bits.
  - An out-of-range access is acked with `err`, but `ram_read` and `ram_write` stay 0.
  - An out-of-range read still completes through RESP and returns `16'h0000` with valid.
  - An out-of-range write is silently dropped.
- **CMD**
  - `ram_read` or `ram_write` is high for exactly this cycle; `ram_address = {8'h00, addr[7:0]}`.
  - Writes return to IDLE; reads go to RESP.
- **RESP**
  - `ram_read` and `ram_write` are 0.
  - At the edge ending RESP, `ram_data_out` (or 0 if trapped) is captured into the owner's rdata register, the owner's valid pulses, and the FSM returns to IDLE.
- **Unused port**
  - The fetch port never writes.
  - The non-owner's rdata and valid are untouched.
- **Reset**
  - Applies asynchronously from any state and drops any in-flight transaction: no ack, valid or err follows.
  - All outputs go to 0; `if_rdata` and `d_rdata` go to `16'h0000`.
  - The FSM goes to IDLE, `last_grant` to I, and `owner` to I.

## Timing
- **Read**
  - Request sampled in IDLE at edge 0.
  - ack and the RAM strobe are high in cycle 1 (CMD).
  - The RAM returns data in cycle 2 (RESP).
  - valid and rdata appear in cycle 3.
  - Total: 3 cycles from the sampling edge to valid.
- **Write**
  - ack and `ram_write` are high in cycle 1.
  - The RAM is updated at the edge ending cycle 1.
  - The FSM is back in IDLE in cycle 2.
- **Back-to-back**
  - A new grant may be sampled in the same IDLE cycle that shows the previous valid.
  - Peak rate: one read per 3 cycles, one write per 2 cycles.
- **Requester behaviour**
  - A requester that keeps `req` high after ack is treated as issuing a new request.
  - ack is never high for both ports in the same cycle.
  - ack never coincides with the same port's valid of an earlier transaction.

## Test plan
- **Single read:** RAM word 52 = 2; `d_req` with `d_addr=16'd52`, `d_we=0`.
  - `d_ack` in cycle 1 with `ram_read=1` and `ram_address=52`.
  - `d_valid` in cycle 3 with `d_rdata=16'd2`.
- **Write then read back:** `d_we=1`, `d_addr=16'd62`, `d_wdata=16'h00AB`.
  - `ram_write=1` for exactly one cycle.
  - A following read of 62 returns `16'h00AB`; `d_valid` never pulses for the write.
- **Round-robin tie:** `if_req` and `d_req` held high continuously, `FIXED_PRIO=0`.
  - Acks go D, I, D, I, …; each port's valid matches its own address.
- **Fixed priority:** both requests held high, `FIXED_PRIO=1`.
  - Only `d_ack` pulses; `if_ack` appears only after `d_req` drops.
- **Out of range:** fetch with `if_addr=16'h0100`, then a data write to `16'd255`.
  - The fetch gives `err` with `if_ack`, `ram_read` stays 0, and `if_valid` pulses with `if_rdata=0`.
  - The write gives `err`, `ram_write` stays 0, and word 255's low-byte alias (word 0xFF) is unchanged.
- **Reset mid-read:** drop `rst_n` during RESP.
  - All outputs go to 0 immediately with no valid.
  - After release, a fetch of address 0 returns the word stored at address 0 with the normal 3-cycle latency.
